// File: rtl/alu_pkg.sv
// Shared opcode/state types and default datapath width for the EX-stage ALU
// with its iterative multiply/divide unit.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLL   = 4'd4,
    OP_SRL   = 4'd5,
    OP_SRA   = 4'd6,
    OP_SGT   = 4'd7,
    OP_SLT   = 4'd8,
    OP_MULT  = 4'd9,
    OP_MULTU = 4'd10,
    OP_DIV   = 4'd11,
    OP_DIVU  = 4'd12,
    OP_MFHI  = 4'd13,
    OP_MFLO  = 4'd14,
    OP_RSVD  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic logic is_muldiv(op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide core: one shift-add or restoring-divide step per
// cycle on operand magnitudes, with a combinational sign fix-up on the result.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // acc:low is the running product for multiply, remainder:quotient for divide
  logic [WIDTH-1:0]   acc, low, mag_b;
  logic               div_r, neg_q, neg_r;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum, shifted, trial;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_neg;

  assign mag_a_in = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b_in = (is_signed && b[WIDTH-1]) ? -b : b;

  assign mul_sum  = {1'b0, acc} + (low[0] ? {1'b0, mag_b} : '0);
  assign shifted  = {acc, low[WIDTH-1]};
  assign trial    = shifted - {1'b0, mag_b};
  assign q_bit    = ~trial[WIDTH];

  assign done     = (cnt == CW'(WIDTH - 1));

  // Quotient negates when signs differ; remainder follows the dividend's sign.
  assign prod_neg = -{acc, low};
  assign lo = div_r ? (neg_q ? -low : low) : (neg_q ? prod_neg[WIDTH-1:0] : low);
  assign hi = div_r ? (neg_r ? -acc : acc) : (neg_q ? prod_neg[2*WIDTH-1:WIDTH] : acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      low   <= '0;
      mag_b <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      acc   <= '0;
      low   <= mag_a_in;
      mag_b <= mag_b_in;
      div_r <= is_div;
      neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= is_signed && a[WIDTH-1];
      cnt   <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (div_r) begin
        acc <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        low <= {low[WIDTH-2:0], q_bit};
      end else begin
        acc <= mul_sum[WIDTH:1];
        low <= {mul_sum[0], low[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with valid/ready handshake: single-cycle simple ops plus an
// iterative multiply/divide unit that owns-by-proxy the architectural HI/LO.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);

  state_e           state;
  op_e              opc;
  logic             accept, div_zero, start;
  logic [WIDTH-1:0] sum, diff, simple_res;
  logic             simple_ovf;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;

  assign opc       = op_e'(op);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign div_zero  = (opc inside {OP_DIV, OP_DIVU}) && (in2 == '0);
  assign start     = accept && is_muldiv(opc) && !div_zero;

  assign sum  = in1 + in2;
  assign diff = in1 - in2;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    simple_res = '0;
    simple_ovf = 1'b0;
    case (opc)
      OP_ADD: begin
        simple_res = sum;
        simple_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        simple_res = diff;
        simple_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  simple_res = in1 & in2;
      OP_OR:   simple_res = in1 | in2;
      OP_SLL:  simple_res = in1 << shamt;
      OP_SRL:  simple_res = in1 >> shamt;
      OP_SRA:  simple_res = $unsigned($signed(in1) >>> shamt);
      OP_SGT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(in1) > $signed(in2))};
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_MFHI: simple_res = hi;
      OP_MFLO: simple_res = lo;
      OP_DIV, OP_DIVU: simple_res = '1;  // only reached on the divide-by-zero path
      default: ;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .run       (state == CALC),
    .is_div    (opc inside {OP_DIV, OP_DIVU}),
    .is_signed (opc inside {OP_MULT, OP_DIV}),
    .a         (in1),
    .b         (in2),
    .done      (mdu_done),
    .hi        (mdu_hi),
    .lo        (mdu_lo)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (start) begin
        state <= CALC;
      end else begin
        state       <= DONE;
        result      <= simple_res;
        overflow    <= simple_ovf;
        zero        <= (simple_res == '0);
        div_by_zero <= div_zero;
        if (div_zero) begin
          hi <= in1;
          lo <= '1;
        end
      end
    end else begin
      case (state)
        CALC: if (mdu_done) state <= FIX;
        FIX: begin
          state       <= DONE;
          hi          <= mdu_hi;
          lo          <= mdu_lo;
          result      <= mdu_lo;
          overflow    <= 1'b0;
          zero        <= (mdu_lo == '0);
          div_by_zero <= 1'b0;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed cases plus a randomized stream
// compared against an in-order arithmetic model with its own HI/LO copy.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [3:0]    op = 4'd0;
  logic [W-1:0]  in1 = '0, in2 = '0;
  logic [SW-1:0] shamt = '0;
  logic          in_ready, out_valid, overflow, zero, div_by_zero;
  logic [W-1:0]  result, hi, lo;

  alu_mdu #(.WIDTH(W), .SHW(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .in1         (in1),
    .in2         (in2),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .hi          (hi),
    .lo          (lo),
    .overflow    (overflow),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res, hi, lo;
    logic         ovf, zero, dbz;
    int           edges;
    time          t_acc;
    bit           seen;
  } exp_t;

  typedef struct {
    logic [W-1:0] res, hi, lo;
    logic         ovf, zero, dbz;
  } obs_t;

  exp_t         q[$];
  obs_t         ret_q[$];
  logic [W-1:0] mhi = '0, mlo = '0;
  int           n_checks = 0, n_err = 0;
  bit           acc, smp_in_ready, rnd_ready = 1'b0;
  time          last_acc_t;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outcome of one op from plain 64-bit arithmetic and the model's HI/LO.
  function automatic exp_t model(op_e o, logic [W-1:0] a, logic [W-1:0] b, logic [SW-1:0] sh);
    exp_t        e;
    longint      sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = '0; e.hi = mhi; e.lo = mlo; e.ovf = 1'b0; e.dbz = 1'b0;
    e.edges = 0; e.t_acc = 0; e.seen = 1'b0;
    case (o)
      OP_ADD: begin s = sa + sb; e.res = a + b; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB: begin s = sa - sb; e.res = a - b; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_SLL: e.res = a << sh;
      OP_SRL: e.res = a >> sh;
      OP_SRA: begin s = sa >>> sh; p = s; e.res = p[W-1:0]; end
      OP_SGT: e.res = (sa > sb) ? 1 : 0;
      OP_SLT: e.res = (sa < sb) ? 1 : 0;
      OP_MULT: begin
        s = sa * sb; p = s;
        e.hi = p[63:32]; e.lo = p[31:0]; e.edges = W + 1;
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.edges = W + 1;
      end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          e.lo = '1; e.hi = a; e.dbz = 1'b1;
        end else begin
          e.edges = W + 1;
          if (o == OP_DIV) begin
            s = sa / sb; p = s; e.lo = p[31:0];
            s = sa % sb; p = s; e.hi = p[31:0];
          end else begin
            p = {32'b0, a} / {32'b0, b}; e.lo = p[31:0];
            p = {32'b0, a} % {32'b0, b}; e.hi = p[31:0];
          end
        end
      end
      OP_MFHI: e.res = mhi;
      OP_MFLO: e.res = mlo;
      default: e.res = '0;
    endcase
    if (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) e.res = e.lo;
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle();
    obs_t o;
    exp_t e;
    bit   ret;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    acc          = in_valid && in_ready;
    smp_in_ready = in_ready;
    ret          = out_valid && out_ready;
    if (ret) begin
      o.res = result; o.hi = hi; o.lo = lo;
      o.ovf = overflow; o.zero = zero; o.dbz = div_by_zero;
      ret_q.push_back(o);
    end
    @(posedge clk);
    if (ret && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      e = model(op_e'(op), in1, in2, shamt);
      e.t_acc = $time;
      last_acc_t = $time;
      q.push_back(e);
      mhi = e.hi;
      mlo = e.lo;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic issue(op_e o, logic [W-1:0] a, logic [W-1:0] b, logic [SW-1:0] sh);
    op = o; in1 = a; in2 = b; shamt = sh; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (acc) break;
    end
    check("accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic run1(op_e o, logic [W-1:0] a, logic [W-1:0] b, logic [SW-1:0] sh, output obs_t r);
    ret_q.delete();
    issue(o, a, b, sh);
    drain();
    check("retired_count", ret_q.size(), 1);
    r.res = 'x; r.hi = 'x; r.lo = 'x; r.ovf = 1'bx; r.zero = 1'bx; r.dbz = 1'bx;
    if (ret_q.size() > 0) r = ret_q[0];
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Compare process: while a result is valid it must match the oldest pending op.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("pending_on_valid", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        if (!q[0].seen) begin
          q[0].seen = 1'b1;
          check("latency", $time - q[0].t_acc, q[0].edges * 10 + 5);
        end
        check("out_bundle", {result, hi, lo, overflow, zero, div_by_zero},
              {q[0].res, q[0].hi, q[0].lo, q[0].ovf, q[0].zero, q[0].dbz});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] simple_ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13, 4'd14, 4'd15};

  initial begin
    obs_t  r;
    exp_t  pin;
    time   t_first;
    logic [W-1:0] held;
    int    sel;
    op_e   o;

    // Model pinned against hand-computed values.
    pin = model(OP_MULT, 32'hFFFF_FFFD, 32'd7, '0);
    check("pin_mult_lo", pin.lo, 32'hFFFF_FFEB);
    pin = model(OP_DIV, 32'hFFFF_FFF9, 32'd2, '0);
    check("pin_div_hi", pin.hi, 32'hFFFF_FFFF);
    pin = model(OP_SUB, 32'h8000_0000, 32'd1, '0);
    check("pin_sub_ovf", pin.ovf, 1'b1);

    #12;
    check("reset_outputs", {out_valid, in_ready, result, hi, lo, overflow, zero, div_by_zero},
          {1'b0, 1'b1, 96'b0, 3'b0});
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    run1(OP_ADD, 32'h7FFF_FFFF, 32'd1, '0, r);
    check("add_res", r.res, 32'h8000_0000);
    check("add_ovf", r.ovf, 1'b1);
    check("add_zero", r.zero, 1'b0);
    run1(OP_SUB, 32'd5, 32'd7, '0, r);
    check("sub_res", r.res, 32'hFFFF_FFFE);
    check("sub_ovf", r.ovf, 1'b0);

    // Back-to-back stream with out_ready held high.
    ret_q.delete();
    issue(OP_SRA, 32'hFFFF_FFF0, '0, 5'd2);
    t_first = last_acc_t;
    issue(OP_SLT, 32'hFFFF_FFF0, 32'd7, '0);
    issue(OP_SUB, 32'd3, 32'd3, '0);
    check("stream_rate", last_acc_t - t_first, 20);
    drain();
    check("stream_count", ret_q.size(), 3);
    if (ret_q.size() >= 3) begin
      check("stream_sra", ret_q[0].res, 32'hFFFF_FFFC);
      check("stream_slt", ret_q[1].res, 32'd1);
      check("stream_sub", ret_q[2].res, 32'd0);
      check("stream_zero", ret_q[2].zero, 1'b1);
    end

    // MULT: in_ready stays low through all iterations and the fix-up cycle.
    ret_q.delete();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, '0);
    for (int i = 0; i < W + 1; i++) begin
      cycle();
      check("mult_in_ready_low", smp_in_ready, 1'b0);
    end
    drain();
    check("mult_count", ret_q.size(), 1);
    if (ret_q.size() > 0) begin
      check("mult_hi", ret_q[0].hi, 32'hFFFF_FFFF);
      check("mult_lo", ret_q[0].lo, 32'hFFFF_FFEB);
    end
    run1(OP_MULTU, 32'hFFFF_FFFF, 32'd2, '0, r);
    check("multu_hilo", {r.hi, r.lo}, {32'd1, 32'hFFFF_FFFE});
    run1(OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, r);
    check("div_hilo", {r.hi, r.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run1(OP_DIVU, 32'd7, 32'd0, '0, r);
    check("divu0_hilo", {r.hi, r.lo, r.res}, {32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    check("divu0_flag", r.dbz, 1'b1);

    // Backpressure after MULT completes.
    out_ready = 1'b0;
    issue(OP_MULT, 32'h1234_5678, 32'h100, '0);
    for (int i = 0; i < 60; i++) begin
      if (out_valid) break;
      cycle();
    end
    check("bp_valid", out_valid, 1'b1);
    held = result;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_in_ready_low", smp_in_ready, 1'b0);
    end
    check("bp_result_held", result, held);
    out_ready = 1'b1;
    cycle();
    drain();
    run1(OP_MFLO, '0, '0, '0, r);
    check("bp_mflo", r.res, 32'h3456_7800);
    check("bp_hi", r.hi, 32'h0000_0012);

    // Reset asserted between clock edges during DIV iteration 10.
    issue(OP_DIV, 32'd1000, 32'd3, '0);
    for (int i = 0; i < 10; i++) cycle();
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {out_valid, in_ready, result, hi, lo, overflow, zero, div_by_zero},
          {1'b0, 1'b1, 96'b0, 3'b0});
    q.delete();
    mhi = '0;
    mlo = '0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    run1(OP_MFHI, '0, '0, '0, r);
    check("abort_mfhi", r.res, 32'd0);

    // Randomized stream with random backpressure and idle gaps.
    rnd_ready = 1'b1;
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 20) o = op_e'(4'($urandom_range(9, 12)));
      else          o = op_e'(simple_ops[$urandom_range(0, 11)]);
      issue(o, rand_opnd(), rand_opnd(), SW'($urandom_range(0, W - 1)));
      if ($urandom_range(0, 3) == 0) cycle();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
